// File: rtl/router_fifo.sv
// Output-channel buffer for the 1x3 router: 16-entry FIFO with a header tag per
// entry and a packet-length counter that idles data_out between packets.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [6:0]       r_count;
  logic [WIDTH-1:0] r_data_out;

  logic             w_full;
  logic             w_empty;
  logic             w_clear;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH:0]   w_rd_entry;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Traffic in a reset or flush cycle is discarded, including the memory write.
  assign w_clear    = !rst || soft_reset;
  assign w_wr       = !w_clear && write_enb && !w_full;
  assign w_rd       = !w_clear && read_enb && !w_empty;
  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rd_entry[WIDTH-1:0];
        // Header byte carries payload length in [7:2]; +1 accounts for parity.
        if (w_rd_entry[WIDTH]) begin
          r_count <= {1'b0, w_rd_entry[7:2]} + 7'd1;
        end else if (r_count != 7'd0) begin
          r_count <= r_count - 7'd1;
        end
      end else if (r_count == 7'd0) begin
        r_data_out <= '0;
      end
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule
